// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: each channel synchronizes an async level, filters it
// for persistence, and reports mode-selected edges as a pulse, sticky flag and saturating count.
module multi_edge_detector_ch #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             pulse,
    output logic             flag,
    output logic [CNT_W-1:0] cnt
);
    localparam int            FW       = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FW-1:0] MIS_LAST = FW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FW-1:0]          mis_q, mis_d;
    logic                   filt_q, filt_d;
    logic                   filt_dly_q, filt_dly_d;
    logic                   pulse_q, pulse_d;
    logic                   flag_q, flag_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   s;
    logic                   ev;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        s      = sync_q[SYNC_STAGES-1];

        // Persistence filter: the level is accepted on the FILT_LEN-th consecutive mismatch.
        filt_d = filt_q;
        mis_d  = '0;
        if (s != filt_q) begin
            if (mis_q == MIS_LAST) filt_d = s;
            else                   mis_d  = mis_q + 1'b1;
        end

        filt_dly_d = filt_q;
        ev = (mode[0] & filt_q & ~filt_dly_q) | (mode[1] & ~filt_q & filt_dly_q);

        pulse_d = ev;
        if (clr) begin
            // An event coinciding with clear is kept rather than lost.
            flag_d = ev;
            cnt_d  = CNT_W'(ev);
        end else begin
            flag_d = flag_q | ev;
            cnt_d  = cnt_q;
            if (ev && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            mis_q      <= '0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
            pulse_q    <= 1'b0;
            flag_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync_q     <= sync_d;
            mis_q      <= mis_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_dly_d;
            pulse_q    <= pulse_d;
            flag_q     <= flag_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pulse = pulse_q;
    assign flag  = flag_q;
    assign cnt   = cnt_q;
endmodule

module multi_edge_detector #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       din,
    input  logic [2*CH-1:0]     mode,
    input  logic [CH-1:0]       clr,
    output logic [CH-1:0]       pulse,
    output logic [CH-1:0]       flag,
    output logic [CH*CNT_W-1:0] edge_cnt,
    output logic                irq
);
    for (genvar i = 0; i < CH; i++) begin : g_ch
        multi_edge_detector_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_LEN   (FILT_LEN),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .din  (din[i]),
            .mode (mode[2*i +: 2]),
            .clr  (clr[i]),
            .pulse(pulse[i]),
            .flag (flag[i]),
            .cnt  (edge_cnt[i*CNT_W +: CNT_W])
        );
    end

    assign irq = |flag;
endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: a history-based model checked every cycle,
// plus hand-computed expectations for latency, glitch, clear, masking, saturation and reset.
module tb_multi_edge_detector;
    localparam int CH   = 4;
    localparam int SS   = 2;
    localparam int FL   = 4;
    localparam int CW   = 8;
    localparam int LOGN = 16384;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH-1:0]    din;
    logic [2*CH-1:0]  mode;
    logic [CH-1:0]    clr;
    logic [CH-1:0]    pulse;
    logic [CH-1:0]    flag;
    logic [CH*CW-1:0] edge_cnt;
    logic             irq;

    multi_edge_detector #(.CH(CH), .SYNC_STAGES(SS), .FILT_LEN(FL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .din(din), .mode(mode), .clr(clr),
        .pulse(pulse), .flag(flag), .edge_cnt(edge_cnt), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pcnt0  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Inputs as seen by each rising edge.
    logic [CH-1:0]   smp_din;
    logic [2*CH-1:0] smp_mode;
    logic [CH-1:0]   smp_clr;
    always @(posedge clk) begin
        smp_din  <= din;
        smp_mode <= mode;
        smp_clr  <= clr;
    end

    // Model: din history since reset; the filtered level is the latest synced value
    // that held for FL consecutive cycles; an edge is a change of that level.
    logic [CH-1:0] din_log [0:LOGN-1];
    logic [CH-1:0] q_log   [0:LOGN-1];
    int            m_n;
    logic [CH-1:0] m_pulse, m_flag;
    int            m_cnt [CH];

    function automatic logic [CH-1:0] s_at(input int j);
        if (j - SS + 1 >= 1) return din_log[j - SS + 1];
        return '0;
    endfunction

    task automatic model_step();
        logic [CH-1:0] qn, qa, qb, sv, sj;
        logic          stab, ev;
        m_n++;
        din_log[m_n] = smp_din;
        sv = s_at(m_n - 1);
        for (int c = 0; c < CH; c++) begin
            stab = 1'b1;
            for (int j = m_n - FL; j < m_n; j++) begin
                sj = s_at(j);
                if (sj[c] != sv[c]) stab = 1'b0;
            end
            qn[c] = stab ? sv[c] : q_log[m_n-1][c];
        end
        q_log[m_n] = qn;
        qa = q_log[m_n-1];
        qb = (m_n >= 2) ? q_log[m_n-2] : '0;
        for (int c = 0; c < CH; c++) begin
            ev = (smp_mode[2*c] & qa[c] & ~qb[c]) | (smp_mode[2*c+1] & ~qa[c] & qb[c]);
            m_pulse[c] = ev;
            if (smp_clr[c]) begin
                m_flag[c] = ev;
                m_cnt[c]  = ev ? 1 : 0;
            end else begin
                m_flag[c] = m_flag[c] | ev;
                if (ev && m_cnt[c] < (1 << CW) - 1) m_cnt[c]++;
            end
        end
    endtask

    always @(negedge clk) begin
        logic [CH*CW-1:0] exp_cnt;
        if (rst) begin
            m_n      = 0;
            m_pulse  = '0;
            m_flag   = '0;
            q_log[0] = '0;
            for (int c = 0; c < CH; c++) m_cnt[c] = 0;
        end else begin
            model_step();
        end
        for (int c = 0; c < CH; c++) exp_cnt[c*CW +: CW] = CW'(m_cnt[c]);
        chk("cyc_pulse", 32'(pulse), 32'(m_pulse));
        chk("cyc_flag",  32'(flag),  32'(m_flag));
        chk("cyc_cnt",   edge_cnt,   exp_cnt);
        chk("cyc_irq",   32'(irq),   32'(|m_flag));
        if (!rst && pulse[0]) pcnt0++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst = 1'b1; din = '0; mode = '0; clr = '0;
        repeat (3) @(negedge clk);
        chk("rst_pulse", 32'(pulse), 0);
        chk("rst_flag",  32'(flag),  0);
        chk("rst_cnt",   edge_cnt,   0);
        chk("rst_irq",   32'(irq),   0);
        #1 rst = 1'b0;

        // Basic latency: rise on ch0 seen 6 edges after the first sampling edge.
        @(negedge clk);
        mode = 8'b0000_0001; din[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk("lat_early", 32'(pulse[0]), 0);
        @(negedge clk);
        chk("lat_pulse", 32'(pulse[0]), 1);
        chk("lat_flag",  32'(flag[0]),  1);
        chk("lat_cnt",   32'(edge_cnt[0 +: CW]), 1);
        chk("lat_irq",   32'(irq), 1);
        @(negedge clk);
        chk("lat_one",   32'(pulse[0]), 0);

        // Glitches: 3 cycles rejected, 4 cycles accepted.
        din[0] = 1'b0;
        repeat (10) @(negedge clk);
        clr = 4'b0001;
        @(negedge clk);
        clr = '0;
        chk("clr0_flag", 32'(flag[0]), 0);
        chk("clr0_cnt",  32'(edge_cnt[0 +: CW]), 0);
        chk("clr0_irq",  32'(irq), 0);
        din[0] = 1'b1;
        repeat (3) @(negedge clk);
        din[0] = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch3_cnt",  32'(edge_cnt[0 +: CW]), 0);
        chk("glitch3_flag", 32'(flag[0]), 0);
        din[0] = 1'b1;
        repeat (4) @(negedge clk);
        din[0] = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch4_cnt", 32'(edge_cnt[0 +: CW]), 1);

        // Clear coinciding with a fall event keeps the event.
        mode[1:0] = 2'b10;
        din[0] = 1'b1;
        repeat (12) @(negedge clk);
        din[0] = 1'b0;
        repeat (6) @(negedge clk);
        clr = 4'b0001;
        @(negedge clk);
        clr = '0;
        chk("clrev_pulse", 32'(pulse[0]), 1);
        chk("clrev_flag",  32'(flag[0]),  1);
        chk("clrev_cnt",   32'(edge_cnt[0 +: CW]), 1);
        clr = 4'b0001;
        @(negedge clk);
        clr = '0;
        chk("clr_flag", 32'(flag[0]), 0);
        chk("clr_cnt",  32'(edge_cnt[0 +: CW]), 0);
        chk("clr_irq",  32'(irq), 0);

        // Masked channel keeps filtering: enabling later gives no spurious edge.
        for (int t = 0; t < 3; t++) begin
            din[1] = ~din[1];
            repeat (10) @(negedge clk);
        end
        mode[3:2] = 2'b01;
        repeat (12) @(negedge clk);
        chk("mask_flag", 32'(flag[1]), 0);
        chk("mask_cnt",  32'(edge_cnt[CW +: CW]), 0);
        din[1] = 1'b0;
        repeat (12) @(negedge clk);
        din[1] = 1'b1;
        repeat (12) @(negedge clk);
        chk("unmask_cnt", 32'(edge_cnt[CW +: CW]), 1);

        // Simultaneous events on two channels.
        mode[7:4] = 4'b1111;
        din[3:2] = 2'b11;
        repeat (7) @(negedge clk);
        chk("simul_pulse", 32'(pulse[3:2]), 32'h3);
        repeat (5) @(negedge clk);
        chk("simul_cnt2", 32'(edge_cnt[2*CW +: CW]), 1);
        chk("simul_cnt3", 32'(edge_cnt[3*CW +: CW]), 1);

        // Saturation: 600 edges in both-edge mode.
        mode[1:0] = 2'b11;
        clr = 4'b0001;
        @(negedge clk);
        clr = '0;
        p0 = pcnt0;
        for (int t = 0; t < 600; t++) begin
            din[0] = ~din[0];
            repeat (10) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("sat_pulses", 32'(pcnt0 - p0), 600);
        chk("sat_cnt",    32'(edge_cnt[0 +: CW]), 255);

        // Asynchronous reset mid-filter, then rise from held-high input.
        din[0] = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_pulse", 32'(pulse), 0);
        chk("arst_flag",  32'(flag),  0);
        chk("arst_cnt",   edge_cnt,   0);
        chk("arst_irq",   32'(irq),   0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_early", 32'(pulse[0]), 0);
        @(negedge clk);
        chk("post_pulse", 32'(pulse[0]), 1);
        chk("post_cnt",   32'(edge_cnt[0 +: CW]), 1);
        chk("post_flags", 32'(flag), 32'hf);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
